// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader into a big-endian instruction store with a combinational fetch port
module imem_loader #(
    parameter int DEPTH_BYTES = 1024,
    parameter int AW          = 10,
    parameter int MAX_WORDS   = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [8:0]  load_len_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    input  logic [31:0] rd_pc_i,
    output logic [31:0] rd_instr_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        cpu_rst_o,
    output logic        err_len_o,
    output logic [8:0]  wr_count_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [8:0] MAX_LEN = 9'(MAX_WORDS);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [8:0]      len_q, len_d;
    logic [8:0]      wr_count_q, wr_count_d;
    logic            err_len_q, err_len_d;
    logic            xfer;

    logic [7:0]      mem_q [DEPTH_BYTES];

    assign xfer = (state_q == S_LOAD) && in_valid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            len_q      <= '0;
            wr_count_q <= '0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            len_q      <= len_d;
            wr_count_q <= wr_count_d;
            err_len_q  <= err_len_d;
        end
    end

    // Store is never cleared; a reset on the same edge as a transfer drops that byte.
    always_ff @(posedge clk_i) begin
        if (xfer && !rst_i) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        len_d      = len_q;
        wr_count_d = wr_count_q;
        err_len_d  = err_len_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    if (load_len_i == 9'd0) begin
                        state_d = S_DONE;
                    end else if (load_len_i <= MAX_LEN) begin
                        len_d      = load_len_i;
                        wr_ptr_d   = '0;
                        wr_count_d = '0;
                        err_len_d  = 1'b0;
                        state_d    = S_LOAD;
                    end else begin
                        err_len_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (xfer) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // The fourth byte of a word completes it.
                    if (wr_ptr_q[1:0] == 2'd3) begin
                        wr_count_d = wr_count_q + 9'd1;
                        if (wr_count_d == len_q) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_ready_o = (state_q == S_LOAD);
    assign busy_o     = (state_q == S_LOAD);
    assign done_o     = (state_q == S_DONE);
    assign cpu_rst_o  = (state_q != S_DONE);
    assign err_len_o  = err_len_q;
    assign wr_count_o = wr_count_q;

    logic [AW-1:0] rd_a0, rd_a1, rd_a2, rd_a3;
    logic          unused_pc_hi;

    assign rd_a0 = rd_pc_i[AW-1:0];
    assign rd_a1 = rd_a0 + AW'(1);
    assign rd_a2 = rd_a0 + AW'(2);
    assign rd_a3 = rd_a0 + AW'(3);
    assign rd_instr_o   = {mem_q[rd_a0], mem_q[rd_a1], mem_q[rd_a2], mem_q[rd_a3]};
    assign unused_pc_hi = ^rd_pc_i[31:AW];

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [8:0]  load_len;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] rd_pc;
    logic [31:0] rd_instr;
    logic        busy;
    logic        done;
    logic        cpu_rst;
    logic        err_len;
    logic [8:0]  wr_count;

    int checks = 0;
    int errors = 0;

    imem_loader dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .load_len_i (load_len),
        .in_valid_i (in_valid),
        .in_data_i  (in_data),
        .in_ready_o (in_ready),
        .rd_pc_i    (rd_pc),
        .rd_instr_o (rd_instr),
        .busy_o     (busy),
        .done_o     (done),
        .cpu_rst_o  (cpu_rst),
        .err_len_o  (err_len),
        .wr_count_o (wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d, input logic cr,
                              input logic rdy, input logic [8:0] cnt);
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
        chk({tag, " cpu_rst"}, 32'(cpu_rst), 32'(cr));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, " wr_count"}, 32'(wr_count), 32'(cnt));
    endtask

    task automatic rd(input string tag, input logic [31:0] pc, input logic [31:0] exp);
        rd_pc = pc;
        #1;
        chk(tag, rd_instr, exp);
    endtask

    task automatic do_start(input logic [8:0] len);
        start    = 1'b1;
        load_len = len;
        tick();
        start    = 1'b0;
        load_len = 9'd0;
    endtask

    logic [7:0] two_word [8];
    logic [7:0] stall_byte [4];
    logic       stall_vld [7];

    initial begin
        two_word   = '{8'h34, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0D};
        stall_byte = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        stall_vld  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; load_len = 9'd0;
        in_valid = 1'b0; in_data = 8'h00; rd_pc = 32'h0000_3000;

        // Reset then idle
        tick(); tick();
        chk_status("reset", 1'b0, 1'b0, 1'b1, 1'b0, 9'd0);
        chk("reset err_len", 32'(err_len), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_status("idle", 1'b0, 1'b0, 1'b1, 1'b0, 9'd0);
        end

        // Two-word load with back-to-back bytes
        do_start(9'd2);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = two_word[i];
            chk("2w busy", 32'(busy), 32'd1);
            chk("2w in_ready", 32'(in_ready), 32'd1);
            tick();
            if (i == 2) chk("2w cnt b3", 32'(wr_count), 32'd0);
            if (i == 3) chk("2w cnt b4", 32'(wr_count), 32'd1);
        end
        in_valid = 1'b0;
        chk_status("2w done", 1'b0, 1'b1, 1'b0, 1'b0, 9'd2);
        rd("2w word0", 32'h0000_3000, 32'h3408_0005);
        rd("2w word1", 32'h0000_3004, 32'h0000_000D);

        // Reload from DONE with stalls, then over-offer
        do_start(9'd1);
        chk("stall cpu_rst reassert", 32'(cpu_rst), 32'd1);
        chk("stall busy", 32'(busy), 32'd1);
        begin
            int k = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = stall_vld[i];
                in_data  = stall_vld[i] ? stall_byte[k] : 8'h5A;
                if (stall_vld[i]) k++;
                tick();
            end
        end
        chk_status("stall done", 1'b0, 1'b1, 1'b0, 1'b0, 9'd1);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("over-offer in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        rd("stall word0", 32'h0000_3000, 32'hAABB_CCDD);
        rd("over-offer mem4", 32'h0000_3004, 32'h0000_000D);

        // Length boundaries
        rst = 1'b1; tick(); rst = 1'b0;
        do_start(9'd0);
        chk_status("len0", 1'b0, 1'b1, 1'b0, 1'b0, 9'd0);
        rd("len0 no write", 32'h0000_3000, 32'hAABB_CCDD);
        do_start(9'd257);
        chk("len257 err_len", 32'(err_len), 32'd1);
        chk_status("len257", 1'b0, 1'b1, 1'b0, 1'b0, 9'd0);
        do_start(9'd256);
        chk("len256 err_len clr", 32'(err_len), 32'd0);
        chk("len256 busy", 32'(busy), 32'd1);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a        = 10'(i);
            in_valid = 1'b1;
            in_data  = a[7:0] ^ {a[9:8], 6'b0};
            tick();
            if (i == 1019) chk("len256 cnt 255", 32'(wr_count), 32'd255);
        end
        in_valid = 1'b0;
        chk_status("len256 done", 1'b0, 1'b1, 1'b0, 1'b0, 9'd256);
        chk("len256 wr_ptr wrap", 32'(dut.wr_ptr_q), 32'd0);
        rd("full 0x000", 32'h0000_3000, 32'h0001_0203);
        rd("full 0x200", 32'h0000_3200, 32'h8081_8283);
        rd("full unaligned 0x101", 32'h0000_3101, 32'h4142_4344);
        rd("full 0x3FC", 32'h0000_33FC, 32'hFCFD_FEFF ^ 32'hC0C0_C0C0);

        // Reset mid-load
        do_start(9'd4);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * 8'(i + 1);
            tick();
        end
        chk("midload cnt", 32'(wr_count), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk_status("midload rst", 1'b0, 1'b0, 1'b1, 1'b0, 9'd0);
        tick();
        chk_status("midload idle", 1'b0, 1'b0, 1'b1, 1'b0, 9'd0);
        rd("midload word0", 32'h0000_3000, 32'h1122_3344);
        rd("midload word1", 32'h0000_3004, 32'h5566_0607);

        // Reload from DONE plus wrap read
        do_start(9'd0);
        chk("reload pre done", 32'(done), 32'd1);
        do_start(9'd1);
        chk("reload cpu_rst", 32'(cpu_rst), 32'd1);
        chk("reload done clr", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        chk_status("reload done", 1'b0, 1'b1, 1'b0, 1'b0, 9'd1);
        rd("reload word0", 32'h0000_3000, 32'h0102_0304);
        rd("wrap read", 32'h0000_33FE, 32'h3E3F_0102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
